// File: rtl/expu_pipe_ctrl.sv
// Elastic valid/ready controller for expu_row register chains.
// Tracks per-stage valid/last bits and drives the row load enables.
module expu_pipe_ctrl #(
  parameter  int unsigned NUM_REGS  = 2,
  parameter  int unsigned CNT_WIDTH = 32,
  localparam int unsigned EN_W      = (NUM_REGS > 0) ? NUM_REGS : 1,
  localparam int unsigned OCC_W     =
    (NUM_REGS < 2) ? 1 : $clog2(NUM_REGS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 valid_i,
  input  logic                 last_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic                 last_o,
  input  logic                 ready_i,
  output logic [EN_W-1:0]      enable_o,
  output logic                 clear_o,
  output logic [OCC_W-1:0]     occupancy_o,
  output logic                 idle_o,
  output logic [CNT_WIDTH-1:0] beats_o
);

  logic                 r_clr;
  logic [CNT_WIDTH-1:0] r_beats;
  logic                 w_acc;

  assign w_acc   = valid_i & ready_o & ~clear_i;
  assign clear_o = r_clr;
  assign beats_o = r_beats;
  assign idle_o  = (occupancy_o == '0) & ~valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_clr   <= 1'b0;
      r_beats <= '0;
    end else begin
      r_clr <= clear_i;
      if (clear_i) begin
        r_beats <= '0;
      end else if (w_acc) begin
        r_beats <= r_beats + 1'b1;
      end
    end
  end

  if (NUM_REGS == 0) begin : g_comb
    assign valid_o     = valid_i;
    assign last_o      = last_i;
    assign ready_o     = ready_i;
    assign enable_o    = '0;
    assign occupancy_o = '0;
  end else begin : g_pipe
    logic [NUM_REGS-1:0] r_v;
    logic [NUM_REGS-1:0] r_l;
    logic [NUM_REGS-1:0] w_vin;
    logic [NUM_REGS-1:0] w_lin;
    logic [NUM_REGS-1:0] w_rdy;
    logic [OCC_W-1:0]    w_occ;

    always_comb begin
      w_vin    = '0;
      w_lin    = '0;
      w_vin[0] = valid_i;
      w_lin[0] = last_i & valid_i;
      for (int j = 1; j < NUM_REGS; j++) begin
        w_vin[j] = r_v[j-1];
        w_lin[j] = r_l[j-1];
      end
    end

    // r[j] = ~v[j] | r[j+1], unrolled: ready unless stages j..end all full
    always_comb begin
      logic w_full;
      w_full = 1'b1;
      w_rdy  = '0;
      for (int j = 0; j < NUM_REGS; j++) begin
        w_full = 1'b1;
        for (int k = j; k < NUM_REGS; k++) begin
          w_full = w_full & r_v[k];
        end
        w_rdy[j] = ready_i | ~w_full;
      end
    end

    always_comb begin
      w_occ = '0;
      for (int j = 0; j < NUM_REGS; j++) begin
        w_occ = w_occ + OCC_W'(r_v[j]);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_v <= '0;
        r_l <= '0;
      end else if (clear_i) begin
        r_v <= '0;
        r_l <= '0;
      end else begin
        for (int j = 0; j < NUM_REGS; j++) begin
          if (w_rdy[j]) begin
            r_v[j] <= w_vin[j];
            r_l[j] <= w_lin[j];
          end
        end
      end
    end

    assign enable_o    = clear_i ? '0 : (w_rdy & w_vin);
    assign ready_o     = w_rdy[0] & ~clear_i;
    assign valid_o     = r_v[NUM_REGS-1];
    assign last_o      = r_l[NUM_REGS-1];
    assign occupancy_o = w_occ;

    a_hold: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (valid_o && !ready_i && !clear_i)
      |=> ($stable(valid_o) && $stable(last_o))
    );
  end

endmodule

// File: tb/tb_expu_pipe_ctrl.sv
// Scoreboard bench for expu_pipe_ctrl at NUM_REGS 2/3/0.
// Tags ride a shadow data path clocked by enable_o.
module tb_expu_pipe_ctrl;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       valid;
  logic       last;
  logic       ready;
  logic [7:0] tag;

  int n_chk;
  int n_fail;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int N  = (g == 0) ? 2 : (g == 1) ? 3 : 0;
    localparam int EW = (N > 0) ? N : 1;
    localparam int OW = (N < 2) ? 1 : $clog2(N + 1);
    localparam int CW = (g == 0) ? 4 : 32;

    logic          rdy_o;
    logic          vld_o;
    logic          lst_o;
    logic          clr_o;
    logic          idle;
    logic [EW-1:0] en;
    logic [OW-1:0] occ;
    logic [CW-1:0] beats;

    expu_pipe_ctrl #(
      .NUM_REGS (N),
      .CNT_WIDTH(CW)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .clear_i    (clear),
      .valid_i    (valid),
      .last_i     (last),
      .ready_o    (rdy_o),
      .valid_o    (vld_o),
      .last_o     (lst_o),
      .ready_i    (ready),
      .enable_o   (en),
      .clear_o    (clr_o),
      .occupancy_o(occ),
      .idle_o     (idle),
      .beats_o    (beats)
    );

    logic [7:0] sd [EW];
    logic [7:0] out_tag;

    always @(posedge clk) begin
      if (en[0]) sd[0] <= tag;
      for (int j = 1; j < N; j++) begin
        if (en[j]) sd[j] <= sd[j-1];
      end
    end

    assign out_tag = (N == 0) ? tag : sd[EW-1];

    logic [8:0]    q[$];
    logic [CW-1:0] acc;
    logic [8:0]    exp_b;

    initial acc = '0;

    always @(negedge clk) begin
      if (rst_n) begin
        if (N > 0) begin
          check($sformatf("d%0d_occ", g), 32'(occ), 32'(q.size()));
        end
        check($sformatf("d%0d_beats", g), 32'(beats), 32'(acc));
        if (valid && rdy_o) begin
          q.push_back({last, tag});
          acc = acc + 1'b1;
        end
        if (vld_o && ready) begin
          if (q.size() == 0) begin
            check($sformatf("d%0d_spurious", g), 32'(vld_o), 32'd0);
          end else begin
            exp_b = q.pop_front();
            check($sformatf("d%0d_out", g),
                  32'({lst_o, out_tag}), 32'(exp_b));
          end
        end
        if (clear) begin
          q.delete();
          acc = '0;
        end
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    clear  = 1'b0;
    valid  = 1'b0;
    last   = 1'b0;
    ready  = 1'b0;
    tag    = 8'd0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(gd[0].rdy_o), 32'd1);
    check("rst_valid", 32'(gd[0].vld_o), 32'd0);
    check("rst_last",  32'(gd[0].lst_o), 32'd0);
    check("rst_occ",   32'(gd[1].occ),   32'd0);
    check("rst_beats", 32'(gd[1].beats), 32'd0);
    check("rst_clr",   32'(gd[0].clr_o), 32'd0);
    check("rst_en",    32'(gd[1].en),    32'd0);
    rst_n = 1'b1;

    // 5 beats, last on beat 5, no backpressure
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      valid = (c < 5);
      last  = (c == 4);
      ready = 1'b1;
      tag   = 8'(8'h10 + c);
      @(negedge clk);
      check("t1_valid", 32'(gd[0].vld_o), 32'(c >= 2 && c <= 6));
      check("t1_last",  32'(gd[0].lst_o), 32'(c == 6));
      check("t1_en", 32'(gd[0].en),
            32'({(c >= 1 && c <= 5), (c < 5)}));
    end
    check("t1_idle",  32'(gd[0].idle),  32'd1);
    check("t1_beats", 32'(gd[0].beats), 32'd5);

    // bubbles: enables follow the valid beat only
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      valid = (c % 2 == 0);
      last  = 1'b0;
      tag   = 8'(8'h20 + c);
      @(negedge clk);
      check("bub_en", 32'(gd[0].en),
            32'({(c % 2 == 1), (c % 2 == 0)}));
    end

    // stall fill on NUM_REGS=3, release with combinational ready
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (4) @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      valid = 1'b1;
      ready = (c == 4);
      tag   = 8'(8'h30 + c);
      @(negedge clk);
      if (c < 3) begin
        check("st_ready", 32'(gd[1].rdy_o), 32'd1);
        check("st_occ",   32'(gd[1].occ),   32'(c));
      end else if (c == 3) begin
        check("st_full_rdy", 32'(gd[1].rdy_o), 32'd0);
        check("st_full_occ", 32'(gd[1].occ),   32'd3);
        check("st_full_vld", 32'(gd[1].vld_o), 32'd1);
      end else begin
        check("st_release", 32'(gd[1].rdy_o), 32'd1);
      end
      @(posedge clk);
    end
    #1;
    valid = 1'b0;
    ready = 1'b1;
    repeat (6) @(posedge clk);

    // clear with two beats in flight and valid high
    for (int c = 0; c < 5; c++) begin
      #1;
      valid = (c < 3);
      clear = (c == 2);
      tag   = 8'(8'h40 + c);
      @(negedge clk);
      if (c == 2) begin
        check("clr_occ2", 32'(gd[0].occ),   32'd2);
        check("clr_rdy",  32'(gd[0].rdy_o), 32'd0);
        check("clr_en",   32'(gd[0].en),    32'd0);
      end else if (c == 3) begin
        check("clr_occ",   32'(gd[0].occ),   32'd0);
        check("clr_beats", 32'(gd[0].beats), 32'd0);
        check("clr_valid", 32'(gd[0].vld_o), 32'd0);
        check("clr_o",     32'(gd[0].clr_o), 32'd1);
      end else if (c == 4) begin
        check("clr_o_end", 32'(gd[0].clr_o), 32'd0);
      end
      @(posedge clk);
    end

    // combinational row: outputs mirror inputs
    for (int i = 0; i < 8; i++) begin
      #1;
      valid = i[0];
      last  = i[1];
      ready = i[2];
      tag   = 8'(8'h50 + i);
      @(negedge clk);
      check("c0_valid", 32'(gd[2].vld_o), 32'(i[0]));
      check("c0_last",  32'(gd[2].lst_o), 32'(i[1]));
      check("c0_ready", 32'(gd[2].rdy_o), 32'(i[2]));
      check("c0_en",    32'(gd[2].en),    32'd0);
      @(posedge clk);
    end
    #1;
    valid = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    check("c0_beats", 32'(gd[2].beats), 32'd2);

    // random traffic; scoreboards track order, occupancy and count
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      valid = ($urandom_range(0, 3) != 0);
      ready = ($urandom_range(0, 3) != 0);
      last  = 1'($urandom_range(0, 1));
      tag   = 8'($urandom);
      clear = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    ready = 1'b1;
    clear = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("drain_q0", 32'(gd[0].q.size()), 32'd0);
    check("drain_q1", 32'(gd[1].q.size()), 32'd0);
    check("drain_idle", 32'(gd[1].idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
